// File: rtl/pcf8563_time_reader.sv
`default_nettype none
// ============================================================================
// Module   : pcf8563_time_reader
// Function : Issues seven single-byte PCF8563 reads through iic_master and
//            publishes a masked, atomic BCD time snapshot with a valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module pcf8563_time_reader #(
    parameter int         TIMEOUT   = 2000000,
    parameter logic [7:0] ADDR_BASE = 8'h02
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       trig,
    output logic       m_start,
    output logic [7:0] m_reg_addr,
    output logic       m_w,
    output logic [7:0] m_wd,
    input  logic [7:0] m_rdata,
    input  logic       m_done,
    output logic [6:0] sec,
    output logic [6:0] min,
    output logic [5:0] hour,
    output logic [5:0] day,
    output logic [2:0] wday,
    output logic [4:0] month,
    output logic       century,
    output logic [7:0] year,
    output logic       vl,
    output logic       bcd_ok,
    output logic       valid,
    output logic       busy,
    output logic       err
);

    localparam int                   C_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [C_CNT_W-1:0]   C_CNT_LAST = C_CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]           C_IDX_LAST = 3'd6;

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_ISSUE  = 2'd1;
    localparam logic [1:0] C_WAIT   = 2'd2;
    localparam logic [1:0] C_COMMIT = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]         shadow_q [7];
    logic [7:0]         shadow_d [7];

    logic [6:0] sec_q, sec_d, min_q, min_d;
    logic [5:0] hour_q, hour_d, day_q, day_d;
    logic [2:0] wday_q, wday_d;
    logic [4:0] month_q, month_d;
    logic [7:0] year_q, year_d;
    logic       century_q, century_d, vl_q, vl_d, bcd_ok_q, bcd_ok_d, valid_q, valid_d;

    logic w_cnt_last;
    logic w_commit;
    logic w_bcd_ok;
    logic w_unused;

    function automatic logic bcd_byte_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    assign w_cnt_last = (cnt_q == C_CNT_LAST);
    assign w_commit   = en && (state_q == C_COMMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= C_IDLE;
            idx_q     <= 3'd0;
            cnt_q     <= '0;
            shadow_q  <= '{default: 8'h00};
            sec_q     <= 7'd0;
            min_q     <= 7'd0;
            hour_q    <= 6'd0;
            day_q     <= 6'd0;
            wday_q    <= 3'd0;
            month_q   <= 5'd0;
            year_q    <= 8'd0;
            century_q <= 1'b0;
            vl_q      <= 1'b0;
            bcd_ok_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            day_q     <= day_d;
            wday_q    <= wday_d;
            month_q   <= month_d;
            year_q    <= year_d;
            century_q <= century_d;
            vl_q      <= vl_d;
            bcd_ok_q  <= bcd_ok_d;
            valid_q   <= valid_d;
        end
    end

    // m_done takes priority over timeout expiry in the same cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        if (en) begin
            case (state_q)
                C_IDLE: begin
                    idx_d = 3'd0;
                    if (trig) state_d = C_ISSUE;
                end
                C_ISSUE: begin
                    cnt_d   = '0;
                    state_d = C_WAIT;
                end
                C_WAIT: begin
                    if (m_done) begin
                        shadow_d[idx_q] = m_rdata;
                        if (idx_q == C_IDX_LAST) begin
                            state_d = C_COMMIT;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = C_ISSUE;
                        end
                    end else if (w_cnt_last) begin
                        idx_d   = 3'd0;
                        state_d = C_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    idx_d   = 3'd0;
                    state_d = C_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        m_start    = en && (state_q == C_ISSUE);
        m_reg_addr = ADDR_BASE + {5'd0, idx_q};
        m_w        = 1'b0;
        m_wd       = 8'h00;
        busy       = (state_q != C_IDLE);
        err        = en && (state_q == C_WAIT) && !m_done && w_cnt_last;
    end

    // Only the masked fields are checked, so bits that never reach an output cannot spoil bcd_ok.
    assign w_bcd_ok = bcd_byte_ok({1'b0, shadow_q[0][6:0]}) &&
                      bcd_byte_ok({1'b0, shadow_q[1][6:0]}) &&
                      bcd_byte_ok({2'b0, shadow_q[2][5:0]}) &&
                      bcd_byte_ok({2'b0, shadow_q[3][5:0]}) &&
                      bcd_byte_ok({3'b0, shadow_q[5][4:0]}) &&
                      bcd_byte_ok(shadow_q[6]);

    always_comb begin
        sec_d     = sec_q;
        vl_d      = vl_q;
        min_d     = min_q;
        hour_d    = hour_q;
        day_d     = day_q;
        wday_d    = wday_q;
        month_d   = month_q;
        century_d = century_q;
        year_d    = year_q;
        bcd_ok_d  = bcd_ok_q;
        valid_d   = w_commit;
        if (w_commit) begin
            sec_d     = shadow_q[0][6:0];
            vl_d      = shadow_q[0][7];
            min_d     = shadow_q[1][6:0];
            hour_d    = shadow_q[2][5:0];
            day_d     = shadow_q[3][5:0];
            wday_d    = shadow_q[4][2:0];
            month_d   = shadow_q[5][4:0];
            century_d = shadow_q[5][7];
            year_d    = shadow_q[6];
            bcd_ok_d  = w_bcd_ok;
        end
    end

    assign w_unused = ^{shadow_q[1][7], shadow_q[2][7:6], shadow_q[3][7:6],
                        shadow_q[4][7:3], shadow_q[5][6:5]};

    assign sec     = sec_q;
    assign min     = min_q;
    assign hour    = hour_q;
    assign day     = day_q;
    assign wday    = wday_q;
    assign month   = month_q;
    assign century = century_q;
    assign year    = year_q;
    assign vl      = vl_q;
    assign bcd_ok  = bcd_ok_q;
    assign valid   = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pcf8563_time_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcf8563_time_reader
// Function : Directed scoreboard bench for pcf8563_time_reader with an
//            iic_master read model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcf8563_time_reader;

    localparam int TIMEOUT = 1100;

    logic clk = 1'b0;
    logic rst, en, trig;
    logic m_start, m_w;
    logic [7:0] m_reg_addr, m_wd;
    logic [7:0] m_rdata_mdl, m_rdata_stray;
    logic m_done_mdl, m_done_stray;
    logic [6:0] sec, min;
    logic [5:0] hour, day;
    logic [2:0] wday;
    logic [4:0] month;
    logic [7:0] year;
    logic century, vl, bcd_ok, valid, busy, err;
    logic [44:0] obs;

    int n_vec = 0, n_bad = 0;
    int cyc = 0, n_valid = 0, n_errp = 0, n_start = 0;
    logic [7:0] addr_log [0:255];
    int start_cyc [0:255];
    int mdelay = 1, long_at = -1, long_delay = 0, hang_at = -1;
    logic [7:0] rd_bytes [0:6];
    logic [44:0] exp_q [$];
    int n0, v0, t0;

    always #5 clk = ~clk;

    pcf8563_time_reader #(.TIMEOUT(TIMEOUT), .ADDR_BASE(8'h02)) u_dut (
        .clk(clk), .rst(rst), .en(en), .trig(trig),
        .m_start(m_start), .m_reg_addr(m_reg_addr), .m_w(m_w), .m_wd(m_wd),
        .m_rdata(m_rdata_mdl | m_rdata_stray), .m_done(m_done_mdl | m_done_stray),
        .sec(sec), .min(min), .hour(hour), .day(day), .wday(wday), .month(month),
        .century(century), .year(year), .vl(vl), .bcd_ok(bcd_ok),
        .valid(valid), .busy(busy), .err(err)
    );

    assign obs = {sec, min, hour, day, wday, month, century, year, vl, bcd_ok};

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (valid === 1'b1) n_valid <= n_valid + 1;
        if (err === 1'b1)   n_errp  <= n_errp + 1;
    end

    // iic_master model: answers each m_start with m_done 'd' cycles later
    initial begin
        m_done_mdl  = 1'b0;
        m_rdata_mdl = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            m_done_mdl  = 1'b0;
            m_rdata_mdl = 8'h00;
            if (m_start === 1'b1) begin
                int n, d, ix;
                n = n_start;
                ix = int'(m_reg_addr) - 2;
                addr_log[n]  = m_reg_addr;
                start_cyc[n] = cyc;
                n_start = n_start + 1;
                d = (n == long_at) ? long_delay : mdelay;
                if (n != hang_at) begin
                    repeat (d) @(posedge clk);
                    #1;
                    m_rdata_mdl = (ix >= 0 && ix < 7) ? rd_bytes[ix] : 8'hEE;
                    m_done_mdl  = 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_vec = n_vec + 1;
        assert (o === e) else begin
            n_bad = n_bad + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
        end
    endtask

    task automatic set_bytes(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
        rd_bytes[0] = b0; rd_bytes[1] = b1; rd_bytes[2] = b2; rd_bytes[3] = b3;
        rd_bytes[4] = b4; rd_bytes[5] = b5; rd_bytes[6] = b6;
    endtask

    function automatic logic nib_bad(input logic [7:0] v);
        return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    endfunction

    function automatic logic [44:0] model();
        logic [7:0] s, mi, h, dd, mo, y;
        logic ok;
        s  = rd_bytes[0] & 8'h7F;
        mi = rd_bytes[1] & 8'h7F;
        h  = rd_bytes[2] & 8'h3F;
        dd = rd_bytes[3] & 8'h3F;
        mo = rd_bytes[5] & 8'h1F;
        y  = rd_bytes[6];
        ok = !(nib_bad(s) || nib_bad(mi) || nib_bad(h) || nib_bad(dd) || nib_bad(mo) || nib_bad(y));
        return {s[6:0], mi[6:0], h[5:0], dd[5:0], rd_bytes[4][2:0], mo[4:0],
                rd_bytes[5][7], y, rd_bytes[0][7], ok};
    endfunction

    // Pulses trig and checks the first ISSUE cycle
    task automatic fire(input string tag);
        n0 = n_start;
        v0 = n_valid;
        t0 = cyc;
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        check({tag, "_issue"}, {m_start, busy, m_w, m_wd, m_reg_addr}, {1'b1, 1'b1, 1'b0, 8'h00, 8'h02});
    endtask

    task automatic wait_starts(input string tag, input int target);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (n_start >= target) begin ok = 1'b1; break; end
            tick(1);
        end
        check({tag, "_start_seen"}, ok, 1);
    endtask

    task automatic collect(input string tag, input int budget, input int exp_lat);
        logic got;
        int bad;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (valid === 1'b1) begin got = 1'b1; break; end
            tick(1);
        end
        trig = 1'b0;
        check({tag, "_valid_seen"}, got, 1);
        if (exp_lat >= 0) check({tag, "_latency"}, cyc - t0, exp_lat);
        if (exp_q.size() == 0) check({tag, "_scoreboard_empty"}, 1, 0);
        else check({tag, "_snapshot"}, obs, exp_q.pop_front());
        check({tag, "_busy_at_valid"}, busy, 0);
        check({tag, "_reads"}, n_start - n0, 7);
        bad = 0;
        for (int i = 0; i < 7; i++)
            if (n0 + i < n_start && addr_log[n0 + i] !== 8'h02 + 8'(i)) bad++;
        check({tag, "_addr_seq"}, bad, 0);
        tick(1);
        check({tag, "_valid_once"}, {valid, 32'(n_valid - v0)}, {1'b0, 32'd1});
    endtask

    initial begin
        logic [44:0] prev;
        logic got;
        rst = 1'b1; en = 1'b1; trig = 1'b0;
        m_done_stray = 1'b0; m_rdata_stray = 8'h00;
        set_bytes(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(3);
        check("reset_outputs", obs, 45'd0);
        check("reset_ctrl", {valid, busy, err, m_start, m_w, m_wd, m_reg_addr},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02});
        rst = 1'b0;
        tick(2);

        // trig without en is ignored
        en = 1'b0; trig = 1'b1;
        tick(3);
        trig = 1'b0; en = 1'b1;
        tick(3);
        check("trig_no_en", {busy, 32'(n_start)}, {1'b0, 32'd0});

        // Nominal snapshot, slow master
        set_bytes(8'h80, 8'h59, 8'h23, 8'h31, 8'h06, 8'h92, 8'h99);
        mdelay = 1000;
        exp_q.push_back({7'h00, 7'h59, 6'h23, 6'h31, 3'd6, 5'h12, 1'b1, 8'h99, 1'b1, 1'b1});
        fire("t1");
        collect("t1", 8000, 2 + 7 * 1001);

        // Non-BCD minutes, fastest master
        set_bytes(8'h80, 8'h3A, 8'h23, 8'h31, 8'h06, 8'h92, 8'h99);
        mdelay = 1;
        exp_q.push_back(model());
        fire("t2");
        collect("t2", 100, 16);
        check("t2_min_bcd", {min, bcd_ok}, {7'h3A, 1'b0});

        // m_done exactly on the last allowed cycle wins over timeout
        set_bytes(8'h45, 8'h30, 8'h12, 8'h05, 8'h02, 8'h07, 8'h24);
        mdelay = TIMEOUT;
        exp_q.push_back(model());
        fire("t3");
        collect("t3", 9000, 2 + 7 * (TIMEOUT + 1));
        check("t3_no_err", n_errp, 0);

        // Timeout on the third read
        set_bytes(8'h11, 8'h22, 8'h33, 8'h14, 8'h05, 8'h06, 8'h77);
        mdelay = 4;
        prev = obs;
        hang_at = n_start + 2;
        fire("t4");
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (err === 1'b1) begin got = 1'b1; break; end
            tick(1);
        end
        check("t4_err_seen", got, 1);
        check("t4_err_delay", cyc - start_cyc[n0 + 2], TIMEOUT);
        tick(1);
        check("t4_after", {err, busy, 32'(n_start - n0)}, {1'b0, 1'b0, 32'd3});
        check("t4_err_once", n_errp, 1);
        check("t4_no_valid", n_valid - v0, 0);
        check("t4_outputs_kept", obs, prev);
        hang_at = -1;

        // trig held through a snapshot, then stray m_done in IDLE and ISSUE
        set_bytes(8'h07, 8'h08, 8'h09, 8'h10, 8'h01, 8'h11, 8'h25);
        mdelay = 3;
        exp_q.push_back(model());
        n0 = n_start; v0 = n_valid; t0 = cyc;
        trig = 1'b1;
        tick(1);
        collect("t5", 200, 2 + 7 * 4);
        tick(30);
        check("t5_no_requeue", {busy, 32'(n_start - n0)}, {1'b0, 32'd7});
        prev = obs;
        v0 = n_valid;
        m_rdata_stray = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            m_done_stray = 1'b1;
            tick(1);
            m_done_stray = 1'b0;
            tick(2);
        end
        check("t5_stray_idle", {obs, busy, 32'(n_valid - v0)}, {prev, 1'b0, 32'd0});
        exp_q.push_back(model());
        fire("t5b");
        m_done_stray = 1'b1;
        tick(1);
        m_done_stray = 1'b0;
        m_rdata_stray = 8'h00;
        collect("t5b", 200, -1);

        // en dropped mid-WAIT with the read close to the timeout limit
        set_bytes(8'h58, 8'h47, 8'h19, 8'h28, 8'h03, 8'h02, 8'h31);
        mdelay = 2;
        long_at = n_start + 1;
        long_delay = TIMEOUT + 10;
        exp_q.push_back(model());
        fire("t6");
        wait_starts("t6", n0 + 2);
        tick(5);
        en = 1'b0;
        tick(10);
        check("t6_hold", {busy, m_start, m_reg_addr}, {1'b1, 1'b0, 8'h03});
        tick(10);
        en = 1'b1;
        collect("t6", 3000, 2 + 6 * 3 + TIMEOUT + 11);
        check("t6_no_err", n_errp, 1);
        long_at = -1;

        // Reset during the fifth WAIT, then a fresh snapshot
        mdelay = 30;
        fire("t7");
        wait_starts("t7", n0 + 5);
        tick(3);
        rst = 1'b1;
        tick(1);
        check("t7_reset_outputs", obs, 45'd0);
        check("t7_reset_ctrl", {valid, busy, m_start, m_reg_addr}, {1'b0, 1'b0, 1'b0, 8'h02});
        rst = 1'b0;
        v0 = n_valid;
        tick(60);
        check("t7_no_commit", {32'(n_valid - v0), 32'(n_start - n0), obs},
              {32'd0, 32'd5, 45'd0});
        set_bytes(8'h21, 8'h43, 8'h05, 8'h09, 8'h04, 8'h86, 8'h00);
        mdelay = 2;
        exp_q.push_back(model());
        fire("t7b");
        collect("t7b", 200, 2 + 7 * 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
